// File: rtl/axis_bit_rate_pkg.sv
// rtl/axis_bit_rate_pkg.sv - shared types and helpers for the bit-rate scheduler
package axis_bit_rate_pkg;

    localparam int RR_MAX_CH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SYNC,
        ST_MEASURE,
        ST_REPORT
    } state_e;

    // First set mask bit strictly after 'last', wrapping; returns 'last' if none is set.
    function automatic int next_rr(input logic [RR_MAX_CH-1:0] mask, input int last, input int n);
        int  idx;
        logic found;
        next_rr = last;
        found   = 1'b0;
        for (int i = 1; i <= RR_MAX_CH; i++) begin
            if (i <= n && !found) begin
                idx = (last + i) % n;
                if (((mask >> idx) & 32'd1) != 32'd0) begin
                    next_rr = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sat_inc = (v >= lim) ? lim : v + 64'd1;
    endfunction

endpackage

// File: rtl/axis_beat_window_counter.sv
// rtl/axis_beat_window_counter.sv - window cycle counter plus saturating beat counter
module axis_beat_window_counter
    import axis_bit_rate_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WINDOW_W   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  count_en_i,
    input  logic                  beat_i,
    input  logic [WINDOW_W-1:0]   window_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] count_o
);

    logic [WINDOW_W-1:0]   win_q, win_d;
    logic [DATA_WIDTH-1:0] beats_q, beats_d;
    logic [63:0]           beats_ext;

    always_comb begin
        beats_ext                   = '0;
        beats_ext[DATA_WIDTH-1:0]   = beats_q;
        win_d                       = win_q;
        beats_d                     = beats_q;
        if (clear_i) begin
            win_d   = '0;
            beats_d = '0;
        end else if (count_en_i) begin
            win_d = win_q + WINDOW_W'(1);
            if (beat_i) begin
                beats_d = DATA_WIDTH'(sat_inc(beats_ext, DATA_WIDTH));
            end
        end
    end

    // Done marks the final cycle of the window; count_o already includes this cycle's beat.
    assign done_o  = count_en_i && ((win_q + WINDOW_W'(1)) == window_i);
    assign count_o = beats_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q   <= '0;
            beats_q <= '0;
        end else begin
            win_q   <= win_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: rtl/axis_bit_rate_sched.sv
// rtl/axis_bit_rate_sched.sv - round-robin beat-rate scheduler over NUM_CH stream taps
module axis_bit_rate_sched
    import axis_bit_rate_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int WINDOW_W   = 32,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [WINDOW_W-1:0]   i_window,
    input  logic [NUM_CH-1:0]     i_ch_mask,
    input  logic [NUM_CH-1:0]     i_valid,
    input  logic [NUM_CH-1:0]     i_ready,
    input  logic [NUM_CH-1:0]     i_last,
    output logic [DATA_WIDTH-1:0] o_beats,
    output logic [CH_W-1:0]       o_ch,
    output logic                  o_sync_timeout,
    output logic                  o_result_valid,
    output logic                  o_sweep_done,
    output logic                  o_busy
);

    state_e                state_q, state_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [WINDOW_W-1:0]   window_q, window_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] res_beats_q, res_beats_d;
    logic [CH_W-1:0]       res_ch_q, res_ch_d;
    logic                  res_timeout_q, res_timeout_d;
    logic                  result_valid_q, result_valid_d;
    logic                  sweep_done_q, sweep_done_d;

    logic [RR_MAX_CH-1:0]  mask_ext;
    logic                  sel_beat, sel_last;
    logic                  cnt_clear, cnt_en, cnt_beat, cnt_done;
    logic [DATA_WIDTH-1:0] cnt_count;

    assign sel_beat = i_valid[ch_q] && i_ready[ch_q];
    assign sel_last = i_last[ch_q];

    axis_beat_window_counter #(
        .DATA_WIDTH(DATA_WIDTH),
        .WINDOW_W  (WINDOW_W)
    ) u_counter (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clear_i   (cnt_clear),
        .count_en_i(cnt_en),
        .beat_i    (cnt_beat),
        .window_i  (window_q),
        .done_o    (cnt_done),
        .count_o   (cnt_count)
    );

    always_comb begin
        mask_ext              = '0;
        mask_ext[NUM_CH-1:0]  = i_ch_mask;
        state_d        = state_q;
        mask_d         = mask_q;
        window_d       = window_q;
        ch_d           = ch_q;
        timeout_d      = timeout_q;
        res_beats_d    = res_beats_q;
        res_ch_d       = res_ch_q;
        res_timeout_d  = res_timeout_q;
        result_valid_d = 1'b0;
        sweep_done_d   = 1'b0;
        cnt_clear      = 1'b0;
        cnt_en         = 1'b0;
        cnt_beat       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_en && (|i_ch_mask)) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                mask_d    = i_ch_mask;
                window_d  = (i_window == '0) ? WINDOW_W'(1) : i_window;
                cnt_clear = 1'b1;
                if (i_ch_mask == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = CH_W'(next_rr(mask_ext, int'(ch_q), NUM_CH));
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                // The aligning boundary beat is not counted; clearing restarts the window for MEASURE.
                cnt_en = 1'b1;
                if (sel_beat && sel_last) begin
                    timeout_d = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = ST_MEASURE;
                end else if (cnt_done) begin
                    timeout_d = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                cnt_en   = 1'b1;
                cnt_beat = sel_beat;
                if (cnt_done) begin
                    state_d        = ST_REPORT;
                    res_beats_d    = cnt_count;
                    res_ch_d       = ch_q;
                    res_timeout_d  = timeout_q;
                    result_valid_d = 1'b1;
                    sweep_done_d   = ((mask_q >> ch_q) == NUM_CH'(1));
                end
            end
            ST_REPORT: begin
                state_d = i_en ? ST_SELECT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            mask_q         <= '0;
            window_q       <= WINDOW_W'(1);
            ch_q           <= CH_W'(NUM_CH - 1);
            timeout_q      <= 1'b0;
            res_beats_q    <= '0;
            res_ch_q       <= '0;
            res_timeout_q  <= 1'b0;
            result_valid_q <= 1'b0;
            sweep_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            window_q       <= window_d;
            ch_q           <= ch_d;
            timeout_q      <= timeout_d;
            res_beats_q    <= res_beats_d;
            res_ch_q       <= res_ch_d;
            res_timeout_q  <= res_timeout_d;
            result_valid_q <= result_valid_d;
            sweep_done_q   <= sweep_done_d;
        end
    end

    assign o_beats        = res_beats_q;
    assign o_ch           = res_ch_q;
    assign o_sync_timeout = res_timeout_q;
    assign o_result_valid = result_valid_q;
    assign o_sweep_done   = sweep_done_q;
    assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: doc/axis_bit_rate_sched.md
Name: axis_bit_rate_sched

Overview:
Round-robin measurement scheduler that shares one beat-counting engine across NUM_CH AXI-Stream monitor taps.
- For each enabled channel in turn, it aligns to a frame boundary (last-beat handshake), then counts accepted beats over a programmable window of clock cycles.
- It reports one result per channel with the channel index.
- It sits beside the stream fabric as a passive observer and feeds the throughput-statistics registers.

Parameters:
NUM_CH, 4, number of monitored stream taps (>=2)
DATA_WIDTH, 32, width of the reported beat count
WINDOW_W, 32, width of the window-length input
CH_W, $clog2(NUM_CH), derived localparam, channel index width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_en  in  1  scheduling enable
i_window  in  WINDOW_W  measurement window length in cycles; 0 treated as 1
i_ch_mask  in  NUM_CH  per-channel enable
i_valid  in  NUM_CH  tap tvalid per channel
i_ready  in  NUM_CH  tap tready per channel
i_last  in  NUM_CH  tap tlast per channel
o_beats  out  DATA_WIDTH  beats accepted in the window, saturating
o_ch  out  CH_W  channel index of o_beats
o_sync_timeout  out  1  result was taken without frame alignment
o_result_valid  out  1  one-cycle pulse qualifying o_beats/o_ch/o_sync_timeout
o_sweep_done  out  1  one-cycle pulse: last enabled channel of a sweep reported
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0. Round-robin pointer set so channel 0 is the first candidate.
- Beat = i_valid[c] && i_ready[c]. Frame boundary = beat && i_last[c]. Only the selected channel c is observed.
- IDLE:
  - i_en && |i_ch_mask -> SELECT.
  - o_busy=0.
- SELECT (1 cycle):
  - Latch i_ch_mask and i_window. A latched window of 0 becomes 1.
  - Pick the first set mask bit strictly after the previously served channel, wrapping.
  - If the latched mask is 0 -> IDLE. Otherwise -> SYNC, with window counter and beat counter cleared.
- SYNC:
  - Frame boundary on the selected channel -> MEASURE next cycle, sync_timeout flag=0. The boundary beat itself is not counted.
  - If no boundary occurs within window cycles -> MEASURE with sync_timeout flag=1.
- MEASURE:
  - Window counter runs 1..window. The beat counter increments on each beat of the selected channel, including a beat on the final window cycle.
  - The beat counter saturates at all-ones and does not wrap.
  - On the final window cycle -> REPORT.
- REPORT (1 cycle):
  - o_beats, o_ch, o_sync_timeout are registered and held until the next REPORT.
  - o_result_valid=1 for this cycle only, i.e. the cycle after the final window cycle.
  - o_sweep_done=1 in the same cycle if the served channel is the highest set bit of the latched mask.
  - Next state: SELECT if i_en=1, else IDLE.
- i_en deasserted mid-SYNC/MEASURE: the current window completes and reports, then IDLE. No abort, no partial result.
- i_ch_mask or i_window changed mid-measurement: no effect until the next SELECT.
- Single enabled channel: the same channel is reselected every pass. o_sweep_done pulses with every result.
- Async reset mid-operation: all outputs drop to 0 immediately. No pending result is emitted after release.
- Counter widths:
  - The window counter is WINDOW_W bits. Comparison is equality against the latched window.
  - The beat counter is DATA_WIDTH bits. A window longer than 2^DATA_WIDTH-1 saturates.

Decomposition:
- Package axis_bit_rate_pkg holds:
  - the state enum (IDLE, SELECT, SYNC, MEASURE, REPORT);
  - a function next_rr(mask, last) returning the next channel index;
  - a saturating-increment function parameterised by width.
- Sub-module axis_beat_window_counter holds:
  - the window counter and the saturating beat counter;
  - inputs: clear, count_en, beat, window;
  - output: done pulse and count.
- The scheduler holds the FSM, latching logic and tap mux.

Test Plan:
- Continuous traffic, single channel: mask=4'b0001, window=8, ch0 valid&ready high continuously, last every 4th beat -> after alignment, result beats=8, ch=0, timeout=0. Results repeat every 1+sync+8+1 cycles; sweep_done pulses with each result.
- Round-robin order: mask=4'b1010, continuous traffic on all channels -> result sequence ch=1,3,1,3. sweep_done pulses only with ch=3.
- Sync timeout: mask=4'b0100, window=16, ch2 valid&ready high, last never asserted -> SYNC lasts 16 cycles, result beats=16, timeout=1.
- Saturation and zero window:
  - DATA_WIDTH=4, window=20, continuous beats -> beats=15.
  - window=0 with one beat per cycle -> beats=1.
- Enable drop mid-window: i_en drops mid-MEASURE (window=32) -> exactly one further result_valid, then o_busy=0 and state=IDLE.
- Async reset mid-window: i_rst_n asserted mid-MEASURE -> o_beats/o_result_valid/o_busy=0 immediately. After release with mask=4'b1111, the first result is ch=0.
